// File: rtl/cache_pkg.sv
// Shared definitions for the cache fill controller: fill FSM states,
// default bus widths and the statistics counter width.
package cache_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_LINE_WIDTH = 32;
  localparam int STAT_WIDTH     = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    CHECK    = 3'd2,
    MEM_REQ  = 3'd3,
    MEM_WAIT = 3'd4,
    FILL     = 3'd5,
    RESP     = 3'd6
  } fill_state_t;

endpackage : cache_pkg

// File: rtl/cache_fill_ctrl_if.sv
// Client-side request/response channel of the cache fill controller.
// The client drives requests (master); the controller answers (slave).
interface cache_fill_ctrl_if
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic [LINE_WIDTH-1:0] rsp_data;
  logic                  rsp_was_hit;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_was_hit
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_was_hit
  );

endinterface : cache_fill_ctrl_if

// File: rtl/cache_fill_ctrl.sv
// Request front-end and miss handler for a K-way CLOCK cache (channel 1).
// One request in flight: probe the cache, on a miss fetch the line from
// backing memory, install it with repeated channel-1 writes until the cache
// reports the line present, then return the data to the client.
// Optional feature macro: CACHE_FILL_STATS_EN adds saturating hit/miss
// counters (hit_count, miss_count).
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  cache_fill_ctrl_if.slave      client,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic [LINE_WIDTH-1:0] c_val,
  output logic                  c_read,
  output logic                  c_write,
  input  logic                  c_hit,
  input  logic [LINE_WIDTH-1:0] c_out_val,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [LINE_WIDTH-1:0] mem_data
`ifdef CACHE_FILL_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] hit_count,
  output logic [STAT_WIDTH-1:0] miss_count
`endif
);

  fill_state_t           r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_line;
  logic                  r_fill_first;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [LINE_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_was_hit;
  logic [ADDR_WIDTH-1:0] r_c_addr;
  logic [LINE_WIDTH-1:0] r_c_val;
  logic                  r_c_read;
  logic                  r_c_write;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr;

  // Fill FSM: every output is a register updated together with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_line        <= '0;
      r_fill_first  <= 1'b0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_was_hit <= 1'b0;
      r_c_addr      <= '0;
      r_c_val       <= '0;
      r_c_read      <= 1'b0;
      r_c_write     <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (client.req_valid && r_req_ready) begin
            r_addr      <= client.req_addr;
            r_c_addr    <= client.req_addr;
            r_c_read    <= 1'b1;
            r_req_ready <= 1'b0;
            r_state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          // The probe lasts exactly one cycle; the cache answers on this edge.
          r_c_read <= 1'b0;
          r_state  <= CHECK;
        end
        CHECK: begin
          if (c_hit) begin
            r_rsp_data    <= c_out_val;
            r_rsp_was_hit <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_addr;
            r_state    <= MEM_REQ;
          end
        end
        MEM_REQ, MEM_WAIT: begin
          if (mem_ack) begin
            r_line       <= mem_data;
            r_mem_req    <= 1'b0;
            r_c_write    <= 1'b1;
            r_c_addr     <= r_addr;
            r_c_val      <= mem_data;
            r_fill_first <= 1'b1;
            r_state      <= FILL;
          end else begin
            r_state <= MEM_WAIT;
          end
        end
        FILL: begin
          // c_hit during the first write cycle still reflects the miss probe.
          if (!r_fill_first && c_hit) begin
            r_c_write     <= 1'b0;
            r_rsp_data    <= r_line;
            r_rsp_was_hit <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_fill_first <= 1'b0;
          end
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_c_read    <= 1'b0;
          r_c_write   <= 1'b0;
          r_mem_req   <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign client.req_ready   = r_req_ready;
  assign client.rsp_valid   = r_rsp_valid;
  assign client.rsp_data    = r_rsp_data;
  assign client.rsp_was_hit = r_rsp_was_hit;
  assign c_addr             = r_c_addr;
  assign c_val              = r_c_val;
  assign c_read             = r_c_read;
  assign c_write            = r_c_write;
  assign mem_req            = r_mem_req;
  assign mem_addr           = r_mem_addr;

`ifdef CACHE_FILL_STATS_EN
  logic [STAT_WIDTH-1:0] r_hit_count;
  logic [STAT_WIDTH-1:0] r_miss_count;

  // Saturating hit/miss counters, bumped once per probe outcome.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == CHECK) begin
      if (c_hit) begin
        if (r_hit_count != {STAT_WIDTH{1'b1}}) r_hit_count <= r_hit_count + STAT_WIDTH'(1);
      end else begin
        if (r_miss_count != {STAT_WIDTH{1'b1}}) r_miss_count <= r_miss_count + STAT_WIDTH'(1);
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule : cache_fill_ctrl

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a behavioural 2-way CLOCK cache
// and a fixed-latency backing memory. Expected values are hand-computed.
module tb_cache_fill_ctrl;
  import cache_pkg::*;

  localparam int AW = 8;
  localparam int LW = 32;
  localparam int MEM_LAT = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] c_addr;
  logic [LW-1:0] c_val;
  logic          c_read;
  logic          c_write;
  logic          c_hit = 1'b0;
  logic [LW-1:0] c_out_val = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic          resp_ack = 1'b0;
  logic          man_ack;
  logic [LW-1:0] mem_data = '0;
  logic          mem_en;
`ifdef CACHE_FILL_STATS_EN
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int excl_bad = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  always #5 clock = ~clock;

  cache_fill_ctrl_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) cif ();

  assign mem_ack = resp_ack | man_ack;

  cache_fill_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clock     (clock),
    .reset     (reset),
    .client    (cif),
    .c_addr    (c_addr),
    .c_val     (c_val),
    .c_read    (c_read),
    .c_write   (c_write),
    .c_hit     (c_hit),
    .c_out_val (c_out_val),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data)
`ifdef CACHE_FILL_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  // Backing-memory contents.
  function automatic logic [LW-1:0] img(input logic [AW-1:0] a);
    case (a)
      8'h10:   return 32'hDEADBEEF;
      8'h20:   return 32'hCAFEF00D;
      8'h30:   return 32'h12345678;
      default: return {4{a}};
    endcase
  endfunction

  // 2-way CLOCK cache model on channel 1; results appear the edge after the op.
  logic          m_vld [2] = '{1'b0, 1'b0};
  logic          m_ref [2] = '{1'b0, 1'b0};
  logic [AW-1:0] m_tag [2] = '{8'h00, 8'h00};
  logic [LW-1:0] m_dat [2] = '{32'h0, 32'h0};
  int            m_hand = 0;
  always @(posedge clock) begin
    int f;
    f = -1;
    for (int i = 0; i < 2; i++) if (m_vld[i] && m_tag[i] == c_addr) f = i;
    if (c_read) begin
      if (f >= 0) begin
        c_hit <= 1'b1; c_out_val <= m_dat[f]; m_ref[f] <= 1'b1;
      end else begin
        c_hit <= 1'b0;
      end
    end else if (c_write) begin
      if (f >= 0) begin
        m_dat[f] <= c_val; m_ref[f] <= 1'b1; c_hit <= 1'b1; c_out_val <= c_val;
      end else if (!m_vld[m_hand] || !m_ref[m_hand]) begin
        m_vld[m_hand] <= 1'b1; m_tag[m_hand] <= c_addr; m_dat[m_hand] <= c_val;
        m_ref[m_hand] <= 1'b1; c_hit <= 1'b1; c_out_val <= c_val;
        m_hand <= 1 - m_hand;
      end else begin
        m_ref[m_hand] <= 1'b0; c_hit <= 1'b0; m_hand <= 1 - m_hand;
      end
    end
  end

  // Fixed-latency memory responder: acks MEM_LAT cycles into a request.
  int mem_cnt = 0;
  always @(posedge clock) begin
    resp_ack <= 1'b0;
    if (mem_en && mem_req && !resp_ack) begin
      if (mem_cnt == MEM_LAT - 1) begin
        resp_ack <= 1'b1; mem_data <= img(mem_addr); mem_cnt <= 0;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else if (!mem_en || !mem_req) begin
      mem_cnt <= 0;
    end
  end

  // Channel-1 read and write must never be asserted together.
  always @(negedge clock) begin
    if (!reset && c_read && c_write) excl_bad = excl_bad + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    logic          hit;
    int            lat;
    int            nreq;
    int            nwr;
  } vec_t;

  // Issue one request from an IDLE cycle and collect what happens until rsp_valid.
  task automatic run_vec(input vec_t v);
    int lat, nreq, nwr, rdy_bad;
    logic prev;
    logic [LW-1:0] d;
    logic h;
    @(negedge clock);
    check("ready_at_issue", {31'd0, cif.req_ready}, 32'd1);
    cif.req_valid = 1'b1;
    cif.req_addr  = v.addr;
    @(posedge clock);
    #1 cif.req_valid = 1'b0;
    lat = -1; nreq = 0; nwr = 0; rdy_bad = 0; prev = 1'b0; d = '0; h = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clock);
      if (cif.req_ready) rdy_bad++;
      if (mem_req && !prev) nreq++;
      prev = mem_req;
      if (c_write) nwr++;
      if (cif.rsp_valid) begin
        lat = i; d = cif.rsp_data; h = cif.rsp_was_hit;
        break;
      end
    end
    if (v.hit) exp_hits++; else exp_miss++;
    check("latency", lat, v.lat);
    check("rsp_data", d, v.data);
    check("rsp_was_hit", {31'd0, h}, {31'd0, v.hit});
    check("mem_req_count", nreq, v.nreq);
    check("write_cycles", nwr, v.nwr);
    check("ready_low_busy", rdy_bad, 0);
  endtask

  vec_t vt [9];

  initial begin
    // addr, data, hit, latency, mem requests, write cycles
    vt[0] = '{8'h10, 32'hDEADBEEF, 1'b0, 10, 1, 2};  // cold miss
    vt[1] = '{8'h10, 32'hDEADBEEF, 1'b1,  3, 0, 0};  // re-read hits
    vt[2] = '{8'h20, 32'hCAFEF00D, 1'b0, 10, 1, 2};  // fills second way
    vt[3] = '{8'h30, 32'h12345678, 1'b0, 12, 1, 4};  // CLOCK sweep evicts 0x10
    vt[4] = '{8'h20, 32'hCAFEF00D, 1'b1,  3, 0, 0};
    vt[5] = '{8'h10, 32'hDEADBEEF, 1'b0, 12, 1, 4};  // evicted line misses again
    vt[6] = '{8'h30, 32'h12345678, 1'b1,  3, 0, 0};
    vt[7] = '{8'h40, 32'h40404040, 1'b0, 12, 1, 4};  // after mid-op reset
    vt[8] = '{8'h40, 32'h40404040, 1'b1,  3, 0, 0};

    reset = 1'b1; man_ack = 1'b0; mem_en = 1'b1;
    cif.req_valid = 1'b0; cif.req_addr = '0;
    #1;
    check("rst_req_ready", {31'd0, cif.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, cif.rsp_valid}, 32'd0);
    check("rst_c_read_write", {30'd0, c_read, c_write}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_rsp_data", cif.rsp_data, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Back-to-back: req_valid held across two hit requests (0x30 then 0x10).
    begin
      int rb_bad;
      rb_bad = 0;
      @(negedge clock);
      cif.req_valid = 1'b1; cif.req_addr = 8'h30;
      @(posedge clock);
      #1 cif.req_addr = 8'h10;
      for (int c = 1; c <= 7; c++) begin
        @(negedge clock);
        if (c == 4) begin
          check("b2b_ready_reopen", {31'd0, cif.req_ready}, 32'd1);
        end else if (cif.req_ready) begin
          rb_bad++;
        end
        if (c == 3) begin
          check("b2b_rsp1_valid", {31'd0, cif.rsp_valid}, 32'd1);
          check("b2b_rsp1_data", cif.rsp_data, 32'h12345678);
        end
        if (c == 5) cif.req_valid = 1'b0;
        if (c == 7) begin
          check("b2b_rsp2_valid", {31'd0, cif.rsp_valid}, 32'd1);
          check("b2b_rsp2_data", cif.rsp_data, 32'hDEADBEEF);
          check("b2b_rsp2_hit", {31'd0, cif.rsp_was_hit}, 32'd1);
        end
      end
      check("b2b_ready_low", rb_bad, 0);
      exp_hits += 2;
    end

    // Reset during MEM_WAIT, then a late mem_ack that must be ignored.
    begin
      int late_bad;
      late_bad = 0;
      mem_en = 1'b0;
      @(negedge clock);
      cif.req_valid = 1'b1; cif.req_addr = 8'h40;
      @(posedge clock);
      #1 cif.req_valid = 1'b0;
      repeat (4) @(negedge clock);
      check("mw_mem_req", {31'd0, mem_req}, 32'd1);
      reset = 1'b1;
      #1;
      exp_hits = 0; exp_miss = 0;
      check("mr_req_ready", {31'd0, cif.req_ready}, 32'd1);
      check("mr_mem_req", {31'd0, mem_req}, 32'd0);
      check("mr_mem_addr", {24'd0, mem_addr}, 32'd0);
      check("mr_c_addr_val", c_val | {24'd0, c_addr}, 32'd0);
      @(negedge clock);
      reset = 1'b0; man_ack = 1'b1;
      @(negedge clock);
      man_ack = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clock);
        if (cif.rsp_valid || c_write || c_read || mem_req || !cif.req_ready) late_bad++;
      end
      check("late_ack_ignored", late_bad, 0);
      mem_en = 1'b1;
    end

    run_vec(vt[7]);
    run_vec(vt[8]);
    check("rd_wr_exclusive", excl_bad, 0);

`ifdef CACHE_FILL_STATS_EN
    check("hit_count", {16'd0, hit_count}, exp_hits);
    check("miss_count", {16'd0, miss_count}, exp_miss);
    @(negedge clock);
    force dut.r_hit_count = 16'hFFFF;
    @(negedge clock);
    release dut.r_hit_count;
    run_vec(vt[8]);
    check("hit_count_sat", {16'd0, hit_count}, 32'h0000FFFF);
    check("miss_count_hold", {16'd0, miss_count}, exp_miss);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_cache_fill_ctrl
